// File: rtl/data_mem_arbiter.sv
// Two-port arbiter for a single-port data memory: port 0 (CPU) and port 1 (loader).
// Define ARB_STARVE_GUARD_EN to add the port 1 starvation guard; otherwise port 0 always wins.
module data_mem_arbiter #(
  parameter int ADDRESS_WIDTH = 18,
  parameter int DATA_WIDTH    = 32,
  parameter int MAX_WAIT      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  p0_req,
  input  logic                  p0_we,
  input  logic [DATA_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  output logic                  p0_gnt,
  output logic                  p0_rvalid,
  output logic [DATA_WIDTH-1:0] p0_rdata,
  input  logic                  p1_req,
  input  logic                  p1_we,
  input  logic [DATA_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  output logic                  p1_gnt,
  output logic                  p1_rvalid,
  output logic [DATA_WIDTH-1:0] p1_rdata,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic                  mem_wen,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  arb_state
);

  // Handshake: a port raises req with stable we/addr/wdata and holds them until gnt;
  // gnt is combinational and the access is performed at the clock edge that sees it.

  if (MAX_WAIT < 1) begin : g_bad_wait
    $error("MAX_WAIT must be at least 1");
  end
  if (ADDRESS_WIDTH > DATA_WIDTH) begin : g_bad_aw
    $error("ADDRESS_WIDTH must not exceed DATA_WIDTH");
  end

  typedef enum logic {P0_PRI = 1'b0, P1_PRI = 1'b1} state_t;

`ifdef ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(MAX_WAIT + 1);

  state_t        state, state_nx;
  logic [CW-1:0] wait_cnt, wait_nx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= P0_PRI;
      wait_cnt <= '0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_nx;
    end
  end

  always_comb begin
    p0_gnt   = 1'b0;
    p1_gnt   = 1'b0;
    state_nx = state;
    wait_nx  = wait_cnt;
    if (rst_n) begin
      if (state == P1_PRI) begin
        if (p1_req)      p1_gnt = 1'b1;
        else if (p0_req) p0_gnt = 1'b1;
      end else begin
        if (p0_req)      p0_gnt = 1'b1;
        else if (p1_req) p1_gnt = 1'b1;
      end
    end
    if (p1_req && !p1_gnt) begin
      if (wait_cnt != CW'(MAX_WAIT)) wait_nx = wait_cnt + 1'b1;
    end else begin
      wait_nx = '0;
    end
    // The MAX_WAIT-th consecutive denial hands priority to port 1 for the next cycle.
    if (state == P0_PRI && p1_req && !p1_gnt && wait_cnt == CW'(MAX_WAIT - 1))
      state_nx = P1_PRI;
    else if (state == P1_PRI && (p1_gnt || !p1_req))
      state_nx = P0_PRI;
  end

  assign arb_state = state;
`else
  always_comb begin
    p0_gnt = rst_n & p0_req;
    p1_gnt = rst_n & p1_req & ~p0_req;
  end

  assign arb_state = P0_PRI;
`endif

  always_comb begin
    mem_addr  = p0_addr;
    mem_wdata = p0_wdata;
    if (p1_gnt) begin
      mem_addr  = p1_addr;
      mem_wdata = p1_wdata;
    end
    mem_wen = (p0_gnt & p0_we) | (p1_gnt & p1_we);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
      p0_rdata  <= '0;
      p1_rdata  <= '0;
    end else begin
      p0_rvalid <= p0_gnt & ~p0_we;
      p1_rvalid <= p1_gnt & ~p1_we;
      if (p0_gnt && !p0_we) p0_rdata <= mem_rdata;
      if (p1_gnt && !p1_we) p1_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed scenarios plus a randomized run against a priority/memory model.
module tb_data_mem_arbiter;
  localparam int MAX_WAIT = 4;
  localparam int MW = 14;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
  logic [31:0] p0_rdata, p1_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_wen;
  logic        arb_state;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mem [0:(1<<MW)-1];
  logic [31:0] ref_mem [0:(1<<MW)-1];
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];

  always #5 clk = ~clk;

  data_mem_arbiter #(.ADDRESS_WIDTH(18), .DATA_WIDTH(32), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .arb_state(arb_state)
  );

  // Single-port memory the arbiter drives: combinational read, write at the edge.
  assign mem_rdata = mem[mem_addr[MW-1:0]];
  always @(posedge clk) if (mem_wen) mem[mem_addr[MW-1:0]] <= mem_wdata;

  task automatic drive(input logic r0, w0, input logic [31:0] a0, d0,
                       input logic r1, w1, input logic [31:0] a1, d1);
    p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
    p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Priority rule: port 1 wins when it requests and either port 0 is idle
  // or port 1 has already been refused MAX_WAIT times in a row.
  function automatic logic [1:0] model_gnt(input logic r0, r1, input int denials);
`ifdef ARB_STARVE_GUARD_EN
    if (r1 && (!r0 || denials >= MAX_WAIT)) return 2'b10;
`else
    if (r1 && !r0) return 2'b10;
`endif
    if (r0) return 2'b01;
    return 2'b00;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1, 1, 32'h10, 32'h1111_1111, 1, 1, 32'h20, 32'h2222_2222);
    #1;
    n_cmp++;
    if (p0_gnt !== 1'b0 || p1_gnt !== 1'b0 || mem_wen !== 1'b0) begin
      n_err++;
      $display("FAIL reset_gnt: gnt0=%b gnt1=%b wen=%b, required 0 0 0", p0_gnt, p1_gnt, mem_wen);
    end
    step();
    step();
    n_cmp++;
    if (p0_rvalid !== 1'b0 || p1_rvalid !== 1'b0 || p0_rdata !== 32'h0 || p1_rdata !== 32'h0) begin
      n_err++;
      $display("FAIL reset_resp: rv0=%b rv1=%b rd0=%h rd1=%h, required zeros", p0_rvalid, p1_rvalid, p0_rdata, p1_rdata);
    end
    n_cmp++;
    if (arb_state !== 1'b0 || mem[16'h10] !== 32'h0) begin
      n_err++;
      $display("FAIL reset_state: state=%b mem[0x10]=%h, required 0 and 0", arb_state, mem[16'h10]);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_write_read();
    drive(1, 1, 32'h10, 32'hDEAD_BEEF, 0, 0, 0, 0);
    #1;
    n_cmp++;
    if (p0_gnt !== 1'b1 || p1_gnt !== 1'b0 || mem_wen !== 1'b1 || mem_addr !== 32'h10 || mem_wdata !== 32'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL p0_write: gnt0=%b gnt1=%b wen=%b addr=%h wdata=%h, required 1 0 1 10 deadbeef",
               p0_gnt, p1_gnt, mem_wen, mem_addr, mem_wdata);
    end
    step();
    n_cmp++;
    if (p0_rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL p0_write_norv: rvalid=%b, required 0", p0_rvalid);
    end
    drive(1, 0, 32'h10, 32'h0, 0, 0, 0, 0);
    #1;
    n_cmp++;
    if (p0_gnt !== 1'b1 || mem_wen !== 1'b0) begin
      n_err++;
      $display("FAIL p0_read_gnt: gnt0=%b wen=%b, required 1 0", p0_gnt, mem_wen);
    end
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (p0_rvalid !== 1'b1 || p0_rdata !== 32'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL p0_read_data: rvalid=%b rdata=%h, required 1 deadbeef", p0_rvalid, p0_rdata);
    end
    n_cmp++;
    if (p1_rvalid !== 1'b0 || p1_rdata !== 32'h0) begin
      n_err++;
      $display("FAIL p1_quiet: rvalid=%b rdata=%h, required 0 0", p1_rvalid, p1_rdata);
    end
    step();
  endtask

  task automatic test_cross_port();
    drive(0, 0, 0, 0, 1, 1, 32'h2710, 32'h7FFF);
    #1;
    n_cmp++;
    if (p1_gnt !== 1'b1 || p0_gnt !== 1'b0 || mem_wen !== 1'b1 || mem_addr !== 32'h2710 || mem_wdata !== 32'h7FFF) begin
      n_err++;
      $display("FAIL p1_write: gnt1=%b gnt0=%b wen=%b addr=%h wdata=%h, required 1 0 1 2710 7fff",
               p1_gnt, p0_gnt, mem_wen, mem_addr, mem_wdata);
    end
    step();
    drive(1, 0, 32'h2710, 0, 0, 0, 0, 0);
    #1;
    n_cmp++;
    if (p0_gnt !== 1'b1 || mem_addr !== 32'h2710) begin
      n_err++;
      $display("FAIL raw_gnt: gnt0=%b addr=%h, required 1 2710", p0_gnt, mem_addr);
    end
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (p0_rvalid !== 1'b1 || p0_rdata !== 32'h7FFF) begin
      n_err++;
      $display("FAIL raw_data: rvalid=%b rdata=%h, required 1 7fff", p0_rvalid, p0_rdata);
    end
    step();
  endtask

  task automatic test_contention();
    logic exp1;
    int ncyc;
`ifdef ARB_STARVE_GUARD_EN
    ncyc = 20;
`else
    ncyc = 100;
`endif
    drive(1, 0, 32'h10, 0, 1, 0, 32'h2710, 0);
    for (int i = 0; i < ncyc; i++) begin
`ifdef ARB_STARVE_GUARD_EN
      exp1 = ((i % (MAX_WAIT + 1)) == MAX_WAIT);
`else
      exp1 = 1'b0;
`endif
      #1;
      n_cmp++;
      if (p1_gnt !== exp1 || p0_gnt !== !exp1) begin
        n_err++;
        $display("FAIL contention_gnt cyc %0d: gnt0=%b gnt1=%b, required %b %b", i, p0_gnt, p1_gnt, !exp1, exp1);
      end
      step();
      n_cmp++;
      if (p1_rvalid !== exp1 || p0_rvalid !== !exp1) begin
        n_err++;
        $display("FAIL contention_rv cyc %0d: rv0=%b rv1=%b, required %b %b", i, p0_rvalid, p1_rvalid, !exp1, exp1);
      end
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step();
  endtask

  task automatic test_reset_pending();
    drive(0, 0, 0, 0, 1, 0, 32'h2710, 0);
    #1;
    n_cmp++;
    if (p1_gnt !== 1'b1) begin
      n_err++;
      $display("FAIL pend_gnt: gnt1=%b, required 1", p1_gnt);
    end
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (p1_rvalid !== 1'b1 || p1_rdata !== 32'h7FFF) begin
      n_err++;
      $display("FAIL pend_pre: rvalid=%b rdata=%h, required 1 7fff", p1_rvalid, p1_rdata);
    end
    rst_n = 1'b0;
    step();
    n_cmp++;
    if (p1_rvalid !== 1'b0 || p1_rdata !== 32'h0 || arb_state !== 1'b0) begin
      n_err++;
      $display("FAIL pend_reset: rvalid=%b rdata=%h state=%b, required 0 0 0", p1_rvalid, p1_rdata, arb_state);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_drop();
    logic exp1;
    drive(1, 0, 32'h10, 0, 1, 0, 32'h2710, 0);
    for (int i = 0; i < 2; i++) begin
      #1;
      n_cmp++;
      if (p1_gnt !== 1'b0 || p0_gnt !== 1'b1) begin
        n_err++;
        $display("FAIL drop_pre cyc %0d: gnt0=%b gnt1=%b, required 1 0", i, p0_gnt, p1_gnt);
      end
      step();
    end
    p1_req = 1'b0;
    step();
    p1_req = 1'b1;
    for (int k = 0; k <= MAX_WAIT; k++) begin
`ifdef ARB_STARVE_GUARD_EN
      exp1 = (k == MAX_WAIT);
`else
      exp1 = 1'b0;
`endif
      #1;
      n_cmp++;
      if (p1_gnt !== exp1 || p0_gnt !== !exp1 || arb_state !== exp1) begin
        n_err++;
        $display("FAIL drop_restart k %0d: gnt0=%b gnt1=%b state=%b, required %b %b %b",
                 k, p0_gnt, p1_gnt, arb_state, !exp1, exp1, exp1);
      end
      step();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step();
  endtask

  task automatic test_random();
    logic        pend0 = 0, pend1 = 0, w0 = 0, w1 = 0;
    logic [31:0] a0 = 0, a1 = 0, d0 = 0, d1 = 0, exp_addr, exp_rd;
    logic [1:0]  g;
    logic        exp_wen;
    int          denials = 0;
    for (int c = 0; c < 400; c++) begin
      if (!pend0 && $urandom_range(0, 1) == 1) begin
        pend0 = 1; w0 = $urandom_range(0, 1) == 1;
        a0 = 32'h100 + $urandom_range(0, 31); d0 = $urandom;
      end
      if (!pend1 && $urandom_range(0, 2) != 0) begin
        pend1 = 1; w1 = $urandom_range(0, 1) == 1;
        a1 = 32'h100 + $urandom_range(0, 31); d1 = $urandom;
      end
      drive(pend0, w0, a0, d0, pend1, w1, a1, d1);
      g = model_gnt(pend0, pend1, denials);
      exp_addr = g[1] ? a1 : a0;
      exp_wen  = (g[0] && w0) || (g[1] && w1);
      #1;
      n_cmp++;
      if ({p1_gnt, p0_gnt} !== g || mem_wen !== exp_wen || mem_addr !== exp_addr) begin
        n_err++;
        $display("FAIL rand_gnt cyc %0d: gnt=%b wen=%b addr=%h, required %b %b %h",
                 c, {p1_gnt, p0_gnt}, mem_wen, mem_addr, g, exp_wen, exp_addr);
      end
      if (exp_wen) begin
        n_cmp++;
        if (mem_wdata !== (g[1] ? d1 : d0)) begin
          n_err++;
          $display("FAIL rand_wdata cyc %0d: wdata=%h, required %h", c, mem_wdata, g[1] ? d1 : d0);
        end
      end
      if (pend1 && !g[1]) denials = (denials < MAX_WAIT) ? denials + 1 : MAX_WAIT;
      else denials = 0;
      if (g[0]) begin
        if (w0) ref_mem[a0[MW-1:0]] = d0; else exp_q0.push_back(ref_mem[a0[MW-1:0]]);
        pend0 = 0;
      end
      if (g[1]) begin
        if (w1) ref_mem[a1[MW-1:0]] = d1; else exp_q1.push_back(ref_mem[a1[MW-1:0]]);
        pend1 = 0;
      end
      step();
      n_cmp++;
      if (p0_rvalid !== (exp_q0.size() != 0) || p1_rvalid !== (exp_q1.size() != 0)) begin
        n_err++;
        $display("FAIL rand_rvalid cyc %0d: rv0=%b rv1=%b, required %b %b",
                 c, p0_rvalid, p1_rvalid, exp_q0.size() != 0, exp_q1.size() != 0);
      end
      if (exp_q0.size() != 0) begin
        exp_rd = exp_q0.pop_front();
        n_cmp++;
        if (p0_rdata !== exp_rd) begin
          n_err++;
          $display("FAIL rand_rdata0 cyc %0d: rdata=%h, required %h", c, p0_rdata, exp_rd);
        end
      end
      if (exp_q1.size() != 0) begin
        exp_rd = exp_q1.pop_front();
        n_cmp++;
        if (p1_rdata !== exp_rd) begin
          n_err++;
          $display("FAIL rand_rdata1 cyc %0d: rdata=%h, required %h", c, p1_rdata, exp_rd);
        end
      end
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step();
  endtask

  initial begin
    for (int i = 0; i < (1 << MW); i++) begin
      mem[i] = 32'h0;
      ref_mem[i] = 32'h0;
    end
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    test_reset();
    test_write_read();
    test_cross_port();
    test_contention();
    test_reset_pending();
    test_drop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-port arbiter that shares the single-port data memory between the CPU load/store path (port 0) and a secondary requester such as a debug/table loader (port 1). It sits between both requesters and the data memory and issues at most one access per cycle. Writes commit at the granting clock edge; read data returns through a registered response one cycle after grant. An optional starvation guard makes sure port 1 is eventually served while the CPU is saturating the memory.

## Interface
- ADDRESS_WIDTH, 18, memory word-index width; the memory uses only the low bits of mem_addr.
- DATA_WIDTH, 32, data and address bus width.
- MAX_WAIT, 4, number of consecutive denied cycles on port 1 before port 1 gets priority (≥1).

- clk  in  1  single clock, all state updates on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- p0_req  in  1  port 0 request; must stay high with stable fields until p0_gnt.
- p0_we  in  1  port 0 write (1) or read (0).
- p0_addr  in  DATA_WIDTH  port 0 address.
- p0_wdata  in  DATA_WIDTH  port 0 write data.
- p0_gnt  out  1  port 0 access is performed this cycle (combinational).
- p0_rvalid  out  1  port 0 read data valid (registered).
- p0_rdata  out  DATA_WIDTH  port 0 read data (registered).
- p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata: port 1, same widths and semantics.
- mem_addr  out  DATA_WIDTH  address to the data memory.
- mem_wen  out  1  memory write enable.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_rdata  in  DATA_WIDTH  memory combinational read data.

## Operation
- FSM with two states: P0_PRI (reset state) and P1_PRI.
- P0_PRI: if p0_req, grant p0; else if p1_req, grant p1.
- P1_PRI: if p1_req, grant p1; else if p0_req, grant p0.
- Exactly one of p0_gnt and p1_gnt is high, or neither is high. Both are forced low while rst_n=0.
- Mux: mem_addr, mem_wdata follow the granted port. mem_wen = gnt & we of the granted port. With no grant: mem_addr=p0_addr, mem_wdata=p0_wdata, mem_wen=0.
- Starvation counter wait_cnt, width $clog2(MAX_WAIT+1):
  - Increments when p1_req=1 and p1_gnt=0, and saturates at MAX_WAIT.
  - Clears when p1_gnt=1 or p1_req=0.
- Transitions:
  - P0_PRI→P1_PRI on the edge where wait_cnt==MAX_WAIT-1 and it increments. Port 1 therefore wins on the cycle after its MAX_WAIT-th denial.
  - P1_PRI→P0_PRI on the edge where p1_gnt=1, or where p1_req=0.
- Read response:
  - On each edge, pX_rvalid <= pX_gnt & ~pX_we.
  - When that value is 1, pX_rdata <= mem_rdata. Otherwise pX_rdata holds its value.
- A write grant produces no rvalid.
- Dropping pX_req before grant is a protocol violation. The arbiter tolerates it: nothing is granted for that port, and the counter clears.

## Timing
- Reset (rst_n low at an edge):
  - State = P0_PRI, wait_cnt=0.
  - p0_rvalid=p1_rvalid=0, p0_rdata=p1_rdata=0.
  - No memory write occurs in a reset cycle.
- Grant latency: 0 cycles, combinational from req and the current state.
- Write commit: at the same posedge where gnt is high.
- Read latency: rvalid and rdata appear 1 cycle after the gnt cycle.
- Throughput: 1 access per cycle. Back-to-back grants to the same port are allowed every cycle.
- Same-cycle requests: the priority state decides. The loser's fields must stay stable.
- Read-after-write from the other port in the next cycle returns the new data.
- Reset asserted while a read is pending: rvalid is not produced; it is cleared to 0.

## Configuration
- ARB_STARVE_GUARD_EN defined: the FSM and wait_cnt are present as described above.
- ARB_STARVE_GUARD_EN undefined:
  - Fixed priority; port 0 always wins.
  - No FSM and no counter; MAX_WAIT is ignored.
  - Port 1 may starve indefinitely.
  - All other behaviour and latencies are unchanged.

## Test plan
- Reset, then p0 write addr 0x10 data 0xDEADBEEF: p0_gnt=1 in the same cycle, mem_wen=1. Then p0 read 0x10: p0_rvalid=1 next cycle with p0_rdata=0xDEADBEEF, and p1 outputs stay 0.
- p0_req and p1_req both held high continuously, MAX_WAIT=4 (macro defined): p0 granted on cycles 0–3, p1 granted on cycle 4, p0 resumes on cycle 5, and the pattern repeats every 5 cycles.
- Same stimulus with the macro undefined: p1_gnt is never asserted over 100 cycles.
- p1 write 0x2710 data 0x7FFF while p0 idle, then p0 read 0x2710 the next cycle: p0_rdata=0x7FFF one cycle after its grant.
- p1 read granted, rst_n low on the following edge: p1_rvalid=0 and p1_rdata=0 after that edge, and the FSM is in P0_PRI.
- p1_req high 2 cycles (denied), dropped 1 cycle, then reasserted: wait_cnt restarts from 0, and p1 wins only after 4 further denials.
